// File: rtl/csr_walker_pkg.sv
// Shared types for the CSR scratch walker: function-table entry, FSM states,
// index-width helper and the per-entry write pattern.
package csr_walker_pkg;

    localparam int CSR_ADDR_W = 32;

    typedef struct packed {
        logic [2:0]            pf;
        logic [10:0]           vf;
        logic                  vfa;
        logic [CSR_ADDR_W-1:0] scratch_addr;
    } t_func_entry;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_WAIT_RSP,
        ST_CHECK,
        ST_NEXT,
        ST_DONE
    } t_walk_state;

    // A single-entry range still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // SEED plus {link, idx} zero-extended; idx occupies the low idx_w bits.
    function automatic logic [63:0] walk_pattern(input logic [63:0] seed,
                                                 input logic [15:0] link,
                                                 input logic [15:0] idx,
                                                 input int          idx_w);
        return seed + ((64'(link) << idx_w) | 64'(idx));
    endfunction

endpackage

// File: rtl/csr_scratch_walker_if.sv
// Table lookup, MMIO request and read-completion signals of the scratch walker.
// master = walker side, slave = function table / MMIO fabric side.
interface csr_scratch_walker_if
    import csr_walker_pkg::*;
#(
    parameter int NUM_LINKS = 1,
    parameter int NUM_FUNCS = 8,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32
);
    localparam int LINK_W = idx_width(NUM_LINKS);
    localparam int IDX_W  = idx_width(NUM_FUNCS);

    logic [LINK_W-1:0] tbl_link;
    logic [IDX_W-1:0]  tbl_idx;
    t_func_entry       tbl_entry;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [LINK_W-1:0] req_link;
    logic [2:0]        req_pf;
    logic [10:0]       req_vf;
    logic              req_vfa;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output tbl_link, tbl_idx,
        output req_valid, req_write, req_link, req_pf, req_vf, req_vfa, req_addr, req_wdata,
        input  tbl_entry, req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  tbl_link, tbl_idx,
        input  req_valid, req_write, req_link, req_pf, req_vf, req_vfa, req_addr, req_wdata,
        output tbl_entry, req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/csr_walker_timeout.sv
// Response wait counter: cleared by load, advanced by tick; expired flags the
// final allowed wait cycle (count == TIMEOUT_CYC-1), combinationally.
module csr_walker_timeout #(
    parameter  int TIMEOUT_CYC = 1024,
    localparam int CNT_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/csr_scratch_walker.sv
// Walks every link/function scratch register: write a pattern, read it back, tally matches.
// One request in flight; WR/RD hold fields stable until req_ready; reads wait up to TIMEOUT_CYC cycles.
module csr_scratch_walker
    import csr_walker_pkg::*;
#(
    parameter  int          NUM_LINKS   = 1,
    parameter  int          NUM_FUNCS   = 8,
    parameter  int          DATA_W      = 64,
    parameter  int          ADDR_W      = 32,
    parameter  int          TIMEOUT_CYC = 1024,
    parameter  logic [63:0] SEED        = 64'hA5A5_0000_0000_0000,
    localparam int          LINK_W      = idx_width(NUM_LINKS),
    localparam int          IDX_W       = idx_width(NUM_FUNCS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    csr_scratch_walker_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          pass_cnt,
    output logic [15:0]          fail_cnt,
    output logic                 timeout_seen,
    output logic [LINK_W-1:0]    first_fail_link,
    output logic [IDX_W-1:0]     first_fail_idx
);

    t_walk_state       state_q, state_d;
    logic [LINK_W-1:0] link_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] rdata_q;
    logic [63:0]       pattern_full;
    logic [DATA_W-1:0] pattern;
    logic              req_valid, req_write;
    logic              tmo_load, tmo_tick, tmo_expired;
    logic              pass_evt, fail_evt, last_idx, last_link;

    assign pattern_full = walk_pattern(SEED, 16'(link_q), 16'(idx_q), IDX_W);
    assign pattern      = pattern_full[DATA_W-1:0];
    assign last_idx     = (idx_q == IDX_W'(NUM_FUNCS - 1));
    assign last_link    = (link_q == LINK_W'(NUM_LINKS - 1));

    csr_walker_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    (tmo_load),
        .tick    (tmo_tick),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        req_write = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        tmo_load  = 1'b0;
        tmo_tick  = 1'b0;
        pass_evt  = 1'b0;
        fail_evt  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_WR;
            end
            ST_WR: begin
                req_valid = 1'b1;
                req_write = 1'b1;
                if (bus.req_ready) state_d = ST_RD;
            end
            ST_RD: begin
                req_valid = 1'b1;
                if (bus.req_ready) begin
                    tmo_load = 1'b1;
                    state_d  = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                // A response on the last allowed cycle still wins over the timeout.
                if (bus.rsp_valid) begin
                    state_d = ST_CHECK;
                end else if (tmo_expired) begin
                    fail_evt = 1'b1;
                    state_d  = ST_NEXT;
                end else begin
                    tmo_tick = 1'b1;
                end
            end
            ST_CHECK: begin
                pass_evt = (rdata_q == pattern);
                fail_evt = (rdata_q != pattern);
                state_d  = ST_NEXT;
            end
            ST_NEXT: begin
                state_d = (last_idx && last_link) ? ST_DONE : ST_WR;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            link_q          <= '0;
            idx_q           <= '0;
            rdata_q         <= '0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            timeout_seen    <= 1'b0;
            first_fail_link <= '0;
            first_fail_idx  <= '0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                link_q          <= '0;
                idx_q           <= '0;
                pass_cnt        <= '0;
                fail_cnt        <= '0;
                timeout_seen    <= 1'b0;
                first_fail_link <= '0;
                first_fail_idx  <= '0;
            end
            if (state_q == ST_WAIT_RSP && bus.rsp_valid) begin
                rdata_q <= bus.rsp_rdata;
            end
            if (state_q == ST_WAIT_RSP && fail_evt) begin
                timeout_seen <= 1'b1;
            end
            if (pass_evt && pass_cnt != 16'hFFFF) begin
                pass_cnt <= pass_cnt + 16'd1;
            end
            if (fail_evt) begin
                if (fail_cnt == 16'h0) begin
                    first_fail_link <= link_q;
                    first_fail_idx  <= idx_q;
                end
                if (fail_cnt != 16'hFFFF) begin
                    fail_cnt <= fail_cnt + 16'd1;
                end
            end
            if (state_q == ST_NEXT) begin
                if (last_idx) begin
                    idx_q  <= '0;
                    link_q <= last_link ? '0 : link_q + LINK_W'(1);
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign bus.tbl_link  = link_q;
    assign bus.tbl_idx   = idx_q;
    assign bus.req_valid = req_valid;
    assign bus.req_write = req_write;
    assign bus.req_link  = link_q;
    assign bus.req_pf    = bus.tbl_entry.pf;
    assign bus.req_vf    = bus.tbl_entry.vf;
    assign bus.req_vfa   = bus.tbl_entry.vfa;
    assign bus.req_addr  = ADDR_W'(bus.tbl_entry.scratch_addr);
    assign bus.req_wdata = pattern;

endmodule

// File: tb/tb_csr_scratch_walker.sv
// Two walkers (1x4 and 2x3 tables) against behavioural echo memories with
// optional stalls, corrupted readback and a silent entry.
module tb_csr_scratch_walker;
    import csr_walker_pkg::*;

    localparam logic [63:0] SEED    = 64'hA5A5_0000_0000_0000;
    localparam int          TMO     = 16;
    localparam int          A_FUNCS = 4;
    localparam int          B_LINKS = 2;
    localparam int          B_FUNCS = 3;

    typedef struct packed {
        logic        wr;
        logic [7:0]  link;
        logic [2:0]  pf;
        logic [10:0] vf;
        logic        vfa;
        logic [31:0] addr;
        logic [63:0] wdata;
    } req_rec_t;

    logic        clk = 1'b0;
    logic        rst, start_a, start_b;
    logic        busy_a, done_a, to_a, busy_b, done_b, to_b;
    logic [15:0] pass_a, fail_a, pass_b, fail_b;
    logic [0:0]  ffl_a, ffl_b;
    logic [1:0]  ffi_a, ffi_b;
    int          checks = 0;
    int          errors = 0;

    t_func_entry tab_a [A_FUNCS];
    t_func_entry tab_b [B_LINKS*B_FUNCS];

    csr_scratch_walker_if #(.NUM_LINKS(1), .NUM_FUNCS(A_FUNCS), .DATA_W(64), .ADDR_W(32)) bus_a ();
    csr_scratch_walker_if #(.NUM_LINKS(B_LINKS), .NUM_FUNCS(B_FUNCS), .DATA_W(64), .ADDR_W(32)) bus_b ();

    csr_scratch_walker #(.NUM_LINKS(1), .NUM_FUNCS(A_FUNCS), .DATA_W(64), .ADDR_W(32),
                         .TIMEOUT_CYC(TMO), .SEED(SEED)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(bus_a),
        .busy(busy_a), .done(done_a), .pass_cnt(pass_a), .fail_cnt(fail_a),
        .timeout_seen(to_a), .first_fail_link(ffl_a), .first_fail_idx(ffi_a)
    );

    csr_scratch_walker #(.NUM_LINKS(B_LINKS), .NUM_FUNCS(B_FUNCS), .DATA_W(64), .ADDR_W(32),
                         .TIMEOUT_CYC(TMO), .SEED(SEED)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(bus_b),
        .busy(busy_b), .done(done_b), .pass_cnt(pass_b), .fail_cnt(fail_b),
        .timeout_seen(to_b), .first_fail_link(ffl_b), .first_fail_idx(ffi_b)
    );

    always #5 clk = ~clk;

    always_comb bus_a.tbl_entry = tab_a[bus_a.tbl_idx];
    always_comb bus_b.tbl_entry = tab_b[int'(bus_b.tbl_link) * B_FUNCS + int'(bus_b.tbl_idx)];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Both configurations have a 2-bit idx field, so {link, idx} = link*4 + idx.
    function automatic req_rec_t exp_rec(input bit wr, input int l, input int i, input t_func_entry e);
        req_rec_t r;
        r.wr    = wr;
        r.link  = 8'(l);
        r.pf    = e.pf;
        r.vf    = e.vf;
        r.vfa   = e.vfa;
        r.addr  = e.scratch_addr;
        r.wdata = wr ? SEED + 64'(l * 4 + i) : 64'h0;
        return r;
    endfunction

    // Entry k lives at address k<<12 plus a random 8-byte-aligned offset.
    function automatic t_func_entry rand_entry(input int k);
        t_func_entry e;
        e.pf           = 3'($urandom_range(0, 7));
        e.vf           = 11'($urandom_range(0, 2047));
        e.vfa          = 1'($urandom_range(0, 1));
        e.scratch_addr = 32'((k << 12) | ($urandom_range(0, 255) << 3));
        return e;
    endfunction

    // ---------------- responder for walker A ----------------
    logic [63:0] mem_a [logic [31:0]];
    req_rec_t    log_a [$];
    bit          stall_en = 1'b0;
    int          corrupt_idx = -1, silent_idx = -1, dly_max = 0;
    int          pend_cnt = -1, stall_left = 0;
    logic [63:0] pend_dat;
    bit          gap_on = 1'b0, was_stalled = 1'b0;
    int          gap_cnt = 0, gap_res = -1;
    req_rec_t    snap;

    always @(negedge clk) begin
        req_rec_t cur;
        int       ri;
        cur = '{wr: bus_a.req_write, link: 8'(bus_a.req_link), pf: bus_a.req_pf, vf: bus_a.req_vf,
                vfa: bus_a.req_vfa, addr: bus_a.req_addr,
                wdata: bus_a.req_write ? bus_a.req_wdata : 64'h0};
        if (was_stalled) begin
            check("stall_valid_held", bus_a.req_valid, 1'b1);
            check("stall_fields_held", 128'(cur), 128'(snap));
        end
        if (gap_on) begin
            if (bus_a.req_valid || !busy_a) begin
                gap_on  = 1'b0;
                gap_res = gap_cnt;
            end else begin
                gap_cnt++;
            end
        end
        bus_a.rsp_valid = 1'b0;
        bus_a.rsp_rdata = {$urandom, $urandom};
        if (pend_cnt == 0) begin
            bus_a.rsp_valid = 1'b1;
            bus_a.rsp_rdata = pend_dat;
            pend_cnt        = -1;
        end else if (pend_cnt > 0) begin
            pend_cnt--;
        end else if (bus_a.req_valid && $urandom_range(0, 3) == 0) begin
            bus_a.rsp_valid = 1'b1;   // stray completion while no read is outstanding
        end
        bus_a.req_ready = 1'b1;
        if (bus_a.req_valid && stall_left > 0) begin
            bus_a.req_ready = 1'b0;
            stall_left--;
        end
        was_stalled = bus_a.req_valid && !bus_a.req_ready;
        snap        = cur;
        if (bus_a.req_valid && bus_a.req_ready) begin
            log_a.push_back(cur);
            stall_left = stall_en ? int'($urandom_range(0, 5)) : 0;
            ri         = int'(cur.addr[15:12]);
            if (cur.wr) begin
                mem_a[cur.addr] = cur.wdata;
            end else if (ri == silent_idx) begin
                gap_on  = 1'b1;
                gap_cnt = 0;
            end else begin
                pend_dat = mem_a[cur.addr] ^ ((ri == corrupt_idx) ? 64'h1 : 64'h0);
                pend_cnt = int'($urandom_range(0, dly_max));
            end
        end
    end

    // ---------------- responder for walker B: ideal echo ----------------
    logic [63:0] mem_b [logic [31:0]];
    req_rec_t    log_b [$];
    bit          pend_b = 1'b0;
    logic [63:0] pend_b_dat;

    always @(negedge clk) begin
        bus_b.rsp_valid = pend_b;
        bus_b.rsp_rdata = pend_b_dat;
        pend_b          = 1'b0;
        bus_b.req_ready = 1'b1;
        if (bus_b.req_valid) begin
            log_b.push_back('{wr: bus_b.req_write, link: 8'(bus_b.req_link), pf: bus_b.req_pf,
                              vf: bus_b.req_vf, vfa: bus_b.req_vfa, addr: bus_b.req_addr,
                              wdata: bus_b.req_write ? bus_b.req_wdata : 64'h0});
            if (bus_b.req_write) begin
                mem_b[bus_b.req_addr] = bus_b.req_wdata;
            end else begin
                pend_b     = 1'b1;
                pend_b_dat = mem_b[bus_b.req_addr];
            end
        end
    end

    task automatic walk_a(input int corr, input int sil, input bit stall, input int dly);
        int dones, exp_fail, exp_first;
        bit fin;
        for (int i = 0; i < A_FUNCS; i++) tab_a[i] = rand_entry(i);
        log_a.delete();
        corrupt_idx = corr;
        silent_idx  = sil;
        stall_en    = stall;
        dly_max     = dly;
        gap_res     = -1;
        dones       = 0;
        fin         = 1'b0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (done_a) dones++;
            if (!busy_a) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        exp_fail  = 0;
        exp_first = -1;
        for (int i = 0; i < A_FUNCS; i++) begin
            if (i == corr || i == sil) begin
                exp_fail++;
                if (exp_first < 0) exp_first = i;
            end
        end
        check("a_walk_finished", fin, 1'b1);
        check("a_done_pulses", dones, 1);
        check("a_pass_cnt", pass_a, A_FUNCS - exp_fail);
        check("a_fail_cnt", fail_a, exp_fail);
        check("a_timeout_seen", to_a, sil >= 0);
        if (exp_fail > 0) begin
            check("a_first_fail_idx", ffi_a, exp_first);
            check("a_first_fail_link", ffl_a, 0);
        end
        check("a_req_count", log_a.size(), 2 * A_FUNCS);
        if (log_a.size() == 2 * A_FUNCS) begin
            for (int i = 0; i < A_FUNCS; i++) begin
                check($sformatf("a_write_req%0d", i), log_a[2*i], exp_rec(1'b1, 0, i, tab_a[i]));
                check($sformatf("a_read_req%0d", i), log_a[2*i+1], exp_rec(1'b0, 0, i, tab_a[i]));
            end
        end
    endtask

    initial begin
        int  dones;
        bit  fin, hit;
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy_a, 1'b0);
        check("reset_done", done_a, 1'b0);
        check("reset_counts", {pass_a, fail_a}, 32'h0);
        check("reset_timeout", to_a, 1'b0);
        check("reset_req_valid", bus_a.req_valid, 1'b0);
        check("reset_indices", {bus_b.tbl_link, bus_b.tbl_idx, ffl_b, ffi_b}, 6'h0);

        walk_a(-1, -1, 1'b0, 0);   // ideal echo
        walk_a(2, -1, 1'b0, 0);    // entry 2 readback corrupted
        walk_a(-1, 1, 1'b0, 0);    // entry 1 never answers
        check("a_timeout_wait_gap", gap_res, TMO + 1);
        walk_a(-1, -1, 1'b1, 3);   // random stalls and response delays
        for (int k = 0; k < 4; k++) begin
            int c, s;
            c = int'($urandom_range(0, A_FUNCS)) - 1;
            s = int'($urandom_range(0, A_FUNCS)) - 1;
            if (s == c) s = -1;
            walk_a(c, s, 1'($urandom_range(0, 1)), 3);
        end

        // Reset (with start) while waiting for the silent entry 2.
        for (int i = 0; i < A_FUNCS; i++) tab_a[i] = rand_entry(i);
        corrupt_idx = 1;
        silent_idx  = 2;
        stall_en    = 1'b0;
        dly_max     = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            hit = gap_on;
        end
        check("rst_reached_wait", hit, 1'b1);
        check("rst_pre_counts", {busy_a, pass_a, fail_a, ffi_a}, {1'b1, 16'd1, 16'd1, 2'd1});
        rst     = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        start_a = 1'b0;
        check("rst_busy", busy_a, 1'b0);
        check("rst_counts", {pass_a, fail_a}, 32'h0);
        check("rst_flags", {done_a, to_a, bus_a.req_valid}, 3'b000);
        check("rst_indices", {ffl_a, ffi_a, bus_a.tbl_idx}, 5'h0);
        dones = 0;
        hit   = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done_a) dones++;
            if (busy_a) hit = 1'b1;
        end
        check("rst_no_done", dones, 0);
        check("rst_stays_idle", hit, 1'b0);

        // Two-link walk: order and pattern.
        for (int k = 0; k < B_LINKS * B_FUNCS; k++) tab_b[k] = rand_entry(k);
        log_b.delete();
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        dones = 0;
        fin   = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (done_b) dones++;
            if (!busy_b) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("b_walk_finished", fin, 1'b1);
        check("b_done_pulses", dones, 1);
        check("b_counts", {pass_b, fail_b, to_b}, {16'd6, 16'd0, 1'b0});
        check("b_req_count", log_b.size(), 2 * B_LINKS * B_FUNCS);
        if (log_b.size() == 2 * B_LINKS * B_FUNCS) begin
            for (int l = 0; l < B_LINKS; l++) begin
                for (int i = 0; i < B_FUNCS; i++) begin
                    check($sformatf("b_write_req_l%0d_i%0d", l, i), log_b[2*(l*B_FUNCS+i)],
                          exp_rec(1'b1, l, i, tab_b[l*B_FUNCS+i]));
                    check($sformatf("b_read_req_l%0d_i%0d", l, i), log_b[2*(l*B_FUNCS+i)+1],
                          exp_rec(1'b0, l, i, tab_b[l*B_FUNCS+i]));
                end
            end
            check("b_pattern_l1_i2", log_b[10].wdata, SEED + 64'd6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
